image_row_streamer: RTL and testbench

Downstream stage of the 32×32 dilation block. It snapshots the processed 1024-bit frame on a start request and streams it row by row to the DNN input layer over a valid/ready handshake. While streaming it counts set pixels, and it reports the total count with a one-cycle done pulse. This decouples the combinational image path from the classifier's consumption rate.

---
 rtl/image_row_streamer.sv | 105 ++++++++++
 tb/tb_image_row_streamer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/image_row_streamer.sv
// rtl/image_row_streamer.sv - snapshots a processed frame and streams it row by row with a set-pixel count
module image_row_streamer #(
    parameter int ROWS = 32,
    parameter int COLS = 32,
    localparam int IDX_W = $clog2(ROWS),
    localparam int CNT_W = $clog2(ROWS*COLS+1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ROWS*COLS-1:0]  frame_in,
    input  logic                  start,
    input  logic                  abort,
    output logic [COLS-1:0]       row_data,
    output logic [IDX_W-1:0]      row_idx,
    output logic                  row_valid,
    output logic                  row_last,
    input  logic                  row_ready,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      pix_count
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                 state;
    logic [ROWS*COLS-1:0]   frame_reg;
    logic [CNT_W-1:0]       acc;
    logic [CNT_W-1:0]       row_pop;
    logic [IDX_W-1:0]       next_idx;

    function automatic logic [CNT_W-1:0] popcount(input logic [COLS-1:0] v);
        logic [CNT_W-1:0] s;
        s = '0;
        for (int i = 0; i < COLS; i++) begin
            s = s + CNT_W'(v[i]);
        end
        return s;
    endfunction

    // Row r occupies the r-th COLS-wide slice counting down from the MSB.
    function automatic logic [COLS-1:0] row_of(input logic [ROWS*COLS-1:0] f,
                                               input logic [IDX_W-1:0] r);
        return f[ROWS*COLS-1-COLS*int'(r) -: COLS];
    endfunction

    assign row_pop  = popcount(row_data);
    assign next_idx = row_idx + IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            frame_reg <= '0;
            acc       <= '0;
            row_data  <= '0;
            row_idx   <= '0;
            row_valid <= 1'b0;
            row_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        frame_reg <= frame_in;
                        acc       <= '0;
                        row_idx   <= '0;
                        row_data  <= frame_in[ROWS*COLS-1 -: COLS];
                        row_valid <= 1'b1;
                        row_last  <= (ROWS == 1) ? 1'b1 : 1'b0;
                        busy      <= 1'b1;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (abort) begin
                        row_valid <= 1'b0;
                        row_last  <= 1'b0;
                        row_idx   <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (row_ready) begin
                        if (row_last) begin
                            pix_count <= acc + row_pop;
                            done      <= 1'b1;
                            row_valid <= 1'b0;
                            row_last  <= 1'b0;
                            row_idx   <= '0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            acc       <= acc + row_pop;
                            row_idx   <= next_idx;
                            row_data  <= row_of(frame_reg, next_idx);
                            row_last  <= (next_idx == IDX_W'(ROWS-1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_row_streamer.sv
// tb/tb_image_row_streamer.sv - randomized bench for image_row_streamer against a frame-level model
module tb_image_row_streamer;
    localparam int ROWS = 32;
    localparam int COLS = 32;
    localparam int N    = ROWS*COLS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [N-1:0]  frame_in = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          row_ready = 1'b0;
    logic [COLS-1:0] row_data;
    logic [4:0]    row_idx;
    logic          row_valid;
    logic          row_last;
    logic          busy;
    logic          done;
    logic [10:0]   pix_count;

    int vectors = 0;
    int errors  = 0;

    image_row_streamer #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst_n(rst_n), .frame_in(frame_in), .start(start), .abort(abort),
        .row_data(row_data), .row_idx(row_idx), .row_valid(row_valid), .row_last(row_last),
        .row_ready(row_ready), .busy(busy), .done(done), .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: which frame is in flight, which row is offered, last reported count.
    logic [N-1:0] m_cap  = '0;
    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;
    int           m_idx  = 0;
    int           m_pix  = 0;

    function automatic int frame_ones(input logic [N-1:0] f);
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(f[N-1-i]);
        return s;
    endfunction

    function automatic logic [COLS-1:0] pixel_row(input logic [N-1:0] f, input int r);
        logic [COLS-1:0] v;
        for (int c = 0; c < COLS; c++) v[COLS-1-c] = f[N-1-(r*COLS+c)];
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cap = '0; m_busy = 0; m_done = 0; m_idx = 0; m_pix = 0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (start && !abort) begin
                    m_cap = frame_in; m_busy = 1; m_idx = 0;
                end
            end else if (abort) begin
                m_busy = 0; m_idx = 0;
            end else if (row_ready) begin
                if (m_idx == ROWS-1) begin
                    m_busy = 0; m_done = 1; m_idx = 0; m_pix = frame_ones(m_cap);
                end else begin
                    m_idx++;
                end
            end
        end
    end

    int xfers = 0;
    always @(negedge clk) begin
        chk("busy", busy, m_busy);
        chk("row_valid", row_valid, m_busy);
        chk("done", done, m_done);
        chk("pix_count", pix_count, m_pix);
        if (m_busy) begin
            chk("row_idx", row_idx, m_idx);
            chk("row_data", row_data, pixel_row(m_cap, m_idx));
            chk("row_last", row_last, (m_idx == ROWS-1));
        end
        if (row_valid && row_ready) xfers++;
    end

    int ready_mode = 0;
    int cyc_g = 0;
    int hook = 0;
    bit hook_seen = 0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc_g++;
        case (ready_mode)
            0: row_ready = 1'b1;
            1: row_ready = (cyc_g % 3 == 0);
            default: row_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic run_frame(input logic [N-1:0] f, output int cyc);
        frame_in = f;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 1000) begin
            step();
            cyc++;
            if (hook == 2 && row_valid && row_idx == 1 && !hook_seen) begin
                chk("single_row1", row_data, 64'h4000_0000);
                hook_seen = 1;
            end
            if (hook == 4 && row_valid && row_idx == 5) frame_in = '0;
            if (hook == 6) start = row_valid && row_idx >= 3 && row_idx <= 6;
        end
        start = 1'b0;
        chk("done_seen", done, 1);
    endtask

    function automatic logic [N-1:0] rand_frame();
        logic [N-1:0] f;
        for (int k = 0; k < N/32; k++) f[k*32 +: 32] = $urandom;
        return f;
    endfunction

    initial begin
        logic [N-1:0] f;
        int cyc, last_pix, cnt;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_row_valid", row_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pix", pix_count, 0);
        chk("rst_row_data", row_data, 0);
        chk("rst_row_idx", row_idx, 0);
        chk("rst_row_last", row_last, 0);
        rst_n = 1'b1;
        step();

        // all-ones, ready tied high
        ready_mode = 0;
        f = '1;
        run_frame(f, cyc);
        chk("allones_latency", cyc, 32);
        chk("allones_pix", pix_count, 1024);
        chk("allones_busy", busy, 0);

        // single pixel at i=33
        hook = 2; hook_seen = 0;
        f = '0; f[N-1-33] = 1'b1;
        run_frame(f, cyc);
        chk("single_row1_seen", hook_seen, 1);
        chk("single_pix", pix_count, 1);
        hook = 0;

        // checkerboard with 1,0,0 backpressure
        ready_mode = 1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                f[N-1-(r*COLS+c)] = ((r + c) % 2 == 0);
        step();
        xfers = 0;
        run_frame(f, cyc);
        step();
        chk("checker_xfers", xfers, 32);
        chk("checker_pix", pix_count, 512);

        // frame_in cleared mid-stream
        ready_mode = 2; hook = 4;
        f = rand_frame();
        run_frame(f, cyc);
        chk("frozen_pix", pix_count, $countones(f));
        last_pix = $countones(f);
        hook = 0;

        // abort at row 10
        ready_mode = 0;
        frame_in = rand_frame();
        start = 1'b1; step(); start = 1'b0;
        cnt = 0;
        while (!(row_valid && row_idx == 10) && cnt < 100) begin step(); cnt++; end
        chk("abort_reached_row10", row_idx, 10);
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort_valid", row_valid, 0);
        chk("abort_done", done, 0);
        chk("abort_pix", pix_count, last_pix);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin step(); if (done) cnt++; end
        chk("abort_no_done", cnt, 0);

        // start pulses during STREAM are ignored
        hook = 6;
        f = rand_frame();
        run_frame(f, cyc);
        hook = 0;
        cnt = 1;
        for (int k = 0; k < 40; k++) begin step(); if (done) cnt++; end
        chk("no_second_frame", cnt, 1);
        chk("ignored_start_pix", pix_count, $countones(f));

        // asynchronous reset at row 20, then a clean frame
        frame_in = rand_frame();
        start = 1'b1; step(); start = 1'b0;
        cnt = 0;
        while (!(row_valid && row_idx == 20) && cnt < 100) begin step(); cnt++; end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", row_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_idx", row_idx, 0);
        chk("midrst_data", row_data, 0);
        chk("midrst_pix", pix_count, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        ready_mode = 2;
        f = rand_frame();
        run_frame(f, cyc);
        chk("post_rst_pix", pix_count, $countones(f));

        // random frames with random backpressure
        for (int t = 0; t < 4; t++) begin
            f = rand_frame();
            run_frame(f, cyc);
            chk("rand_pix", pix_count, $countones(f));
        end
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
